// File: rtl/option_pkg.sv
// option_pkg: shared sizes, mode encodings and FSM state type for the path replay buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package option_pkg;

  localparam int DW     = 12;
  localparam int DAY    = 8;
  localparam int N_PATH = 256;
  localparam int WORDS  = DAY * N_PATH;
  localparam int AW     = $clog2(WORDS);
  localparam int DAYW   = $clog2(DAY);
  localparam int PW     = 8;

  localparam logic [1:0] MODE_IDLE    = 2'd0;
  localparam logic [1:0] MODE_CAPTURE = 2'd1;
  localparam logic [1:0] MODE_REPLAY  = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  localparam logic [AW-1:0]   LAST_ADDR = AW'(WORDS - 1);
  localparam logic [DAYW-1:0] DAY_LAST  = DAYW'(DAY - 1);
  localparam logic [PW-1:0]   PATH_LAST = PW'(N_PATH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FULL,
    ST_REPLAY,
    ST_DONE
  } state_t;

  // RAM address of day 0 of path p.
  function automatic logic [AW-1:0] path_base(input logic [PW-1:0] p);
    return AW'(p) * AW'(DAY);
  endfunction

endpackage

// File: rtl/path_ram.sv
// path_ram: single-port synchronous RAM holding every captured path word.
// Latency: 1 cycle from re to rdata (registered read output).
// Backpressure: none; rdata holds whenever re is low.
// Ports: clk/rst (rst clears only the read register), we/wdata write at addr,
//   re loads rdata from addr.
module path_ram
  import option_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/path_replay_buffer.sv
// path_replay_buffer: captures N_PATH x DAY path words into RAM, then replays them in capture order.
// Latency: first replay word 1 cycle after entering REPLAY, then 1 word/cycle; a resend costs one bubble.
// Backpressure: none by default; with PATH_BUF_READY_EN, out_ready low freezes the read register and outputs.
// Ports: clk, rst (async, active-high); mode 0 idle / 1 capture / 2 replay / 3 idle;
//   in_valid/in_data capture stream; resend restarts the current path at day 0;
//   out_valid/out_data/out_last/path_idx replay stream; full/done/overflow status.
// Optional macro PATH_BUF_READY_EN adds the out_ready input.
module path_replay_buffer
  import option_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          resend,
`ifdef PATH_BUF_READY_EN
  input  logic          out_ready,
`endif
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          full,
  output logic          done,
  output logic          overflow,
  output logic [PW-1:0] path_idx
);

`ifdef PATH_BUF_READY_EN
  // out_ready comes from the port list.
`else
  logic out_ready;
  assign out_ready = 1'b1;
`endif

  state_t          state, state_nxt;
  logic [AW-1:0]   wptr, rptr, ram_addr;
  logic [DAYW-1:0] day;
  logic [PW-1:0]   path;
  logic            mode_idle, consume, adv;
  logic            start_cap, start_rep, abort, restart, finish, issue, cap_wr;

  assign mode_idle = (mode == MODE_IDLE) || (mode == MODE_RSVD);
  assign consume   = out_valid && out_ready;
  // The RAM read register doubles as the output register, so a new read
  // may only be issued when that register is empty or being consumed.
  assign adv       = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_cap = 1'b0;
    start_rep = 1'b0;
    abort     = 1'b0;
    restart   = 1'b0;
    finish    = 1'b0;
    issue     = 1'b0;
    cap_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_CAPTURE) begin
          state_nxt = ST_CAPTURE;
          start_cap = 1'b1;
        end else if (mode == MODE_REPLAY && full) begin
          state_nxt = ST_REPLAY;
          start_rep = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (mode_idle) begin
          state_nxt = ST_IDLE;
        end else if (in_valid) begin
          cap_wr = 1'b1;
          if (wptr == LAST_ADDR) state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (mode == MODE_CAPTURE) begin
          state_nxt = ST_CAPTURE;
          start_cap = 1'b1;
        end else if (mode == MODE_REPLAY) begin
          state_nxt = ST_REPLAY;
          start_rep = 1'b1;
        end
      end
      ST_REPLAY: begin
        // Abort beats resend; resend beats the end-of-replay exit so a
        // resend on the very last word replays the last path again.
        if (mode_idle) begin
          state_nxt = ST_IDLE;
          abort     = 1'b1;
        end else if (resend) begin
          restart = 1'b1;
        end else if (consume && out_last && path_idx == PATH_LAST) begin
          state_nxt = ST_DONE;
          finish    = 1'b1;
        end else begin
          issue = adv;
        end
      end
      ST_DONE: begin
        if (mode_idle) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ram_addr = (state == ST_CAPTURE) ? wptr : rptr;

  path_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (cap_wr),
    .re    (issue),
    .addr  (ram_addr),
    .wdata (in_data),
    .rdata (out_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      day       <= '0;
      path      <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      path_idx  <= '0;
    end else begin
      if (start_cap) begin
        wptr     <= '0;
        full     <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (cap_wr) wptr <= wptr + AW'(1);
        if (cap_wr && wptr == LAST_ADDR) full <= 1'b1;
        if (full && in_valid) overflow <= 1'b1;
      end

      if (start_rep || abort) begin
        rptr      <= '0;
        day       <= '0;
        path      <= '0;
        path_idx  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (restart) begin
        // path_idx names the word on the output, which is the path to
        // restart even when the read side has already moved to the next one.
        rptr      <= path_base(path_idx);
        day       <= '0;
        path      <= path_idx;
        out_valid <= 1'b0;
      end else if (finish) begin
        out_valid <= 1'b0;
        done      <= 1'b1;
      end else if (issue) begin
        rptr      <= rptr + AW'(1);
        day       <= (day == DAY_LAST) ? '0 : day + DAYW'(1);
        if (day == DAY_LAST) path <= path + PW'(1);
        out_valid <= 1'b1;
        out_last  <= (day == DAY_LAST);
        path_idx  <= path;
      end

      if (state == ST_DONE && mode_idle) done <= 1'b0;
    end
  end

endmodule

// File: doc/path_replay_buffer.md
Name: path_replay_buffer

Overview:
- Sits between the path generator's output stream and the pricing stage's path input.
- Captures every generated path word (N_PATH paths × DAY days) into an on-chip RAM.
- In pricing mode it streams the paths back out in order, one word per cycle.
- A `resend` pulse from the pricing stage restarts the current path at day 0.

Parameters:
- DW, 12, path word width.
- DAY, 8, words per path.
- N_PATH, 256, number of paths stored.
- AW, $clog2(DAY*N_PATH), RAM address width (derived; 11 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  0 = idle, 1 = capture, 2 = replay, 3 = reserved (treated as idle).
- in_valid  in  1  capture word strobe.
- in_data  in  DW  path word to capture.
- resend  in  1  single-cycle request to replay the current path from day 0.
- out_valid  out  1  out_data holds a valid replay word.
- out_data  out  DW  replayed path word.
- out_last  out  1  high with the final word (day DAY-1) of each path.
- full  out  1  capture complete (DAY*N_PATH words stored).
- done  out  1  all paths replayed.
- overflow  out  1  sticky; an in_valid arrived while full.
- path_idx  out  8  index of the path currently replaying.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; write/read pointers, day and path counters 0.
- FSM states: IDLE, CAPTURE, FULL, REPLAY, DONE.
- IDLE:
  - mode=1 → CAPTURE, write pointer cleared, overflow cleared.
  - mode=2 → REPLAY only if full=1; otherwise stay in IDLE.
- CAPTURE:
  - Each in_valid writes in_data at wptr; wptr increments.
  - The write of word DAY*N_PATH-1 sets full on the next cycle and moves to FULL.
  - mode=0 → IDLE; captured data is kept, full stays 0.
- FULL:
  - in_valid is ignored and sets overflow.
  - mode=2 → REPLAY with rptr, day and path counters at 0.
  - mode=1 restarts capture: full cleared, go to CAPTURE.
- REPLAY:
  - Synchronous RAM read, 1-cycle latency: first out_valid arrives one cycle after entering REPLAY.
  - After that, one word per cycle, in capture order.
  - out_last is asserted when day=DAY-1; path_idx increments after each out_last.
- resend in REPLAY:
  - rptr is set to path_idx*DAY on the next cycle.
  - The word already in flight is suppressed: out_valid=0 for exactly one cycle.
  - Day 0 of the same path then follows.
- resend coincident with out_last: resend wins; path_idx is not advanced and the same path is replayed.
- Last word of the last path without resend → DONE on the next cycle; done=1, out_valid=0.
- DONE: mode=0 → IDLE; done is held until then. full stays set, so replay can run again.
- mode=0 during REPLAY → IDLE immediately:
  - out_valid drops the next cycle.
  - Counters are cleared; RAM contents are kept.
- resend outside REPLAY: ignored.
- Counter widths wrap naturally: the day counter is 0..DAY-1; the path counter never exceeds N_PATH-1 because of the DONE exit.

Optional Feature:
- Macro PATH_BUF_READY_EN.
- Defined: adds input `out_ready` (1 bit).
  - A word is consumed only when out_valid && out_ready.
  - When stalled, out_data, out_last and path_idx hold.
  - The RAM read register is gated so no word is lost or duplicated.
  - resend during a stall still restarts the path.
- Undefined: no port; out_ready is internally tied to 1 and behaviour is as above.

Decomposition:
- Shared package `option_pkg`: DW, DAY, N_PATH, mode encodings (MODE_IDLE/CAPTURE/REPLAY), FSM state enum.
- One sub-module, `path_ram`: single-port synchronous RAM, DW × DAY*N_PATH, registered read output.
- FSM and counters live in path_replay_buffer.

Test Plan:
- Full capture: mode=1, stream 2048 words valued addr[11:0] → full=1 one cycle after word 2047; overflow=0.
- Overflow: one extra in_valid after full → overflow=1, RAM word 0 unchanged on replay.
- Basic replay: mode=2 after full → first out_valid one cycle later with out_data=0.
  - out_last on words 7, 15, …; path_idx steps 0→1 after word 7.
  - done=1 after word 2047.
- Resend mid-path: resend at path 3 day 5 → one bubble, then out_data=24 (path 3 day 0); path_idx stays 3.
- Resend on out_last: resend coincident with path 10 day 7 → replays from word 80; path_idx=10.
- Abort and reset: mode=0 during replay → out_valid=0 next cycle, state IDLE. Then mode=2 → replay restarts at word 0. Async rst mid-capture → all outputs 0 immediately.
